// File: rtl/io_task_scheduler.sv
// io_task_scheduler: keeps a pending bitmap of channel/thread tasks and
// offers one task at a time to instruction fetch using a ready/ack handshake.
// The winner is chosen round-robin over every pending channel/thread pair.
//
// Optional build macro: IO_TASK_SCHED_CH0_PRIORITY_EN.
// When it is defined, channel 0 has strict priority (lowest thread first),
// and channel-0 grants leave the round-robin pointer where it is.
module io_task_scheduler #(
  parameter int CHANNELS = 8,
  parameter int THREADS  = 4,
  parameter int CH_W     = 3,
  parameter int TH_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wake_valid,
  input  logic [CH_W-1:0]        wake_channel,
  input  logic [TH_W-1:0]        wake_thread,
  input  logic                   cancel_valid,
  input  logic [CH_W-1:0]        cancel_channel,
  input  logic [TH_W-1:0]        cancel_thread,
  output logic                   next_task_ready,
  output logic [CH_W-1:0]        next_task_channel,
  output logic [TH_W-1:0]        next_task_thread,
  input  logic                   next_task_ack,
  output logic                   pending_any,
  output logic [CH_W+TH_W:0]     pending_count
);

  localparam int N     = CHANNELS * THREADS;
  localparam int IDX_W = CH_W + TH_W;
  localparam int CNT_W = CH_W + TH_W + 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state;
  logic [N-1:0]       pending;
  logic [N-1:0]       pending_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   wake_idx;
  logic [IDX_W-1:0]   cancel_idx;
  logic [IDX_W-1:0]   offer_idx;
  logic [IDX_W-1:0]   winner_idx;
  logic [IDX_W-1:0]   probe;
  logic               winner_found;
  logic               grant;
  logic [CNT_W-1:0]   count_next;

  // Task index is channel*THREADS + thread, i.e. the channel/thread fields concatenated.
  assign wake_idx   = {wake_channel, wake_thread};
  assign cancel_idx = {cancel_channel, cancel_thread};
  assign offer_idx  = {next_task_channel, next_task_thread};
  assign grant      = (state == OFFER) && next_task_ack;

  // Next bitmap: the grant clears first, so a same-cycle wake re-arms the
  // granted task, and a cancel is applied last so it always has the final word.
  always_comb begin
    pending_next = pending;
    if (grant) pending_next[offer_idx] = 1'b0;
    if (wake_valid) pending_next[wake_idx] = 1'b1;
    if (cancel_valid) pending_next[cancel_idx] = 1'b0;
  end

  // Population count of the next bitmap, registered with the bitmap itself.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + CNT_W'(pending_next[i]);
    end
  end

  // Winner search over the registered bitmap, starting at rr_ptr and wrapping;
  // the index arithmetic wraps naturally because N is a power of two.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    probe        = '0;
    for (int i = 0; i < N; i++) begin
      probe = rr_ptr + IDX_W'(i);
      if (!winner_found && pending[probe]) begin
        winner_found = 1'b1;
        winner_idx   = probe;
      end
    end
`ifdef IO_TASK_SCHED_CH0_PRIORITY_EN
    if (|pending[THREADS-1:0]) begin
      winner_found = 1'b1;
      winner_idx   = '0;
      for (int t = THREADS - 1; t >= 0; t--) begin
        if (pending[t]) winner_idx = IDX_W'(t);
      end
    end
`endif
  end

  // Bitmap, status outputs and the IDLE/OFFER handshake FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pending           <= '0;
      rr_ptr            <= '0;
      next_task_ready   <= 1'b0;
      next_task_channel <= '0;
      next_task_thread  <= '0;
      pending_any       <= 1'b0;
      pending_count     <= '0;
    end else begin
      pending       <= pending_next;
      pending_any   <= |pending_next;
      pending_count <= count_next;
      case (state)
        IDLE: begin
          if (winner_found) begin
            next_task_channel <= winner_idx[IDX_W-1:TH_W];
            next_task_thread  <= winner_idx[TH_W-1:0];
            next_task_ready   <= 1'b1;
            state             <= OFFER;
          end
        end
        OFFER: begin
          if (next_task_ack) begin
`ifdef IO_TASK_SCHED_CH0_PRIORITY_EN
            if (next_task_channel != '0) rr_ptr <= offer_idx + IDX_W'(1);
`else
            rr_ptr <= offer_idx + IDX_W'(1);
`endif
            next_task_ready <= 1'b0;
            state           <= IDLE;
          end else if (cancel_valid && (cancel_idx == offer_idx)) begin
            next_task_ready <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          next_task_ready <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_task_scheduler.sv
// Testbench for io_task_scheduler: directed scenarios followed by random
// traffic, all compared cycle by cycle against a task-level reference model.
module tb_io_task_scheduler;

  localparam int CHANNELS = 8;
  localparam int THREADS  = 4;
  localparam int CH_W     = 3;
  localparam int TH_W     = 2;
  localparam int N        = CHANNELS * THREADS;

  logic                clk = 1'b0;
  logic                reset;
  logic                wake_valid;
  logic [CH_W-1:0]     wake_channel;
  logic [TH_W-1:0]     wake_thread;
  logic                cancel_valid;
  logic [CH_W-1:0]     cancel_channel;
  logic [TH_W-1:0]     cancel_thread;
  logic                next_task_ready;
  logic [CH_W-1:0]     next_task_channel;
  logic [TH_W-1:0]     next_task_thread;
  logic                next_task_ack;
  logic                pending_any;
  logic [CH_W+TH_W:0]  pending_count;

  io_task_scheduler #(
    .CHANNELS(CHANNELS), .THREADS(THREADS), .CH_W(CH_W), .TH_W(TH_W)
  ) dut (
    .clk(clk), .reset(reset),
    .wake_valid(wake_valid), .wake_channel(wake_channel), .wake_thread(wake_thread),
    .cancel_valid(cancel_valid), .cancel_channel(cancel_channel), .cancel_thread(cancel_thread),
    .next_task_ready(next_task_ready), .next_task_channel(next_task_channel),
    .next_task_thread(next_task_thread), .next_task_ack(next_task_ack),
    .pending_any(pending_any), .pending_count(pending_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a set of pending task indices, the round-robin start
  // point, and the task currently on offer (if any).
  bit m_pend[N];
  int m_rr    = 0;
  bit m_ready = 1'b0;
  int m_off   = 0;
  int dut_grants[$];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic int m_winner();
`ifdef IO_TASK_SCHED_CH0_PRIORITY_EN
    for (int t = 0; t < THREADS; t++) if (m_pend[t]) return t;
`endif
    for (int k = 0; k < N; k++) if (m_pend[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare every output.
  task automatic apply_stimulus(input bit rst, input bit wv, input int wi,
                                input bit cv, input int ci, input bit ak);
    bit nxt[N];
    int w;
    reset          = rst;
    wake_valid     = wv;
    wake_channel   = CH_W'(wi / THREADS);
    wake_thread    = TH_W'(wi % THREADS);
    cancel_valid   = cv;
    cancel_channel = CH_W'(ci / THREADS);
    cancel_thread  = TH_W'(ci % THREADS);
    next_task_ack  = ak;
    if (!rst && next_task_ready && ak)
      dut_grants.push_back(int'({next_task_channel, next_task_thread}));
    nxt = m_pend;
    if (m_ready && ak) nxt[m_off] = 1'b0;
    if (wv) nxt[wi] = 1'b1;
    if (cv) nxt[ci] = 1'b0;
    if (rst) begin
      foreach (nxt[i]) nxt[i] = 1'b0;
      m_rr = 0; m_ready = 1'b0; m_off = 0;
    end else if (m_ready) begin
      if (ak) begin
`ifdef IO_TASK_SCHED_CH0_PRIORITY_EN
        if (m_off >= THREADS) m_rr = (m_off + 1) % N;
`else
        m_rr = (m_off + 1) % N;
`endif
        m_ready = 1'b0;
      end else if (cv && ci == m_off) begin
        m_ready = 1'b0;
      end
    end else begin
      w = m_winner();
      if (w >= 0) begin m_off = w; m_ready = 1'b1; end
    end
    m_pend = nxt;
    @(posedge clk);
    #1;
    check_output("ready", next_task_ready, m_ready);
    check_output("channel", next_task_channel, m_off / THREADS);
    check_output("thread", next_task_thread, m_off % THREADS);
    check_output("pending_any", pending_any, m_count() != 0);
    check_output("pending_count", pending_count, m_count());
  endtask

  task automatic idle(input int n, input bit ak);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, ak);
  endtask

  initial begin
    int pick;
    // Reset and quiet cycles.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(4, 1'b0);
    check_output("rst_ready", next_task_ready, 0);
    check_output("rst_count", pending_count, 0);

    // Wake ch7/th0: offered two edges later, held while ack is low, then granted.
    apply_stimulus(1'b0, 1'b1, 28, 1'b0, 0, 1'b0);
    check_output("wake_lat_edge1", next_task_ready, 0);
    idle(1, 1'b0);
    check_output("wake_lat_ready", next_task_ready, 1);
    check_output("wake_lat_ch", next_task_channel, 7);
    check_output("wake_lat_th", next_task_thread, 0);
    idle(5, 1'b0);
    check_output("hold_ch", next_task_channel, 7);
    idle(1, 1'b1);
    check_output("ack_ready", next_task_ready, 0);
    check_output("ack_count", pending_count, 0);

    // Round-robin order with ack held high, then wrap-around.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    dut_grants.delete();
    apply_stimulus(1'b0, 1'b1, 3, 1'b0, 0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 6, 1'b0, 0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 21, 1'b0, 0, 1'b1);
    idle(4, 1'b1);
    apply_stimulus(1'b0, 1'b1, 30, 1'b0, 0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 3, 1'b0, 0, 1'b1);
    idle(3, 1'b1);
    check_output("rr_grants", dut_grants.size(), 5);
    check_output("rr_g0", dut_grants[0], 3);
    check_output("rr_g1", dut_grants[1], 6);
    check_output("rr_g2", dut_grants[2], 21);
    check_output("rr_g3_wrap", dut_grants[3], 30);
    check_output("rr_g4_wrap", dut_grants[4], 3);

    // Cancel of the offered task withdraws it; same-cycle wake+cancel leaves 0.
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 9, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    check_output("cancel_offer_ch", next_task_channel, 2);
    check_output("cancel_offer_th", next_task_thread, 1);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 9, 1'b0);
    check_output("cancel_ready", next_task_ready, 0);
    check_output("cancel_count", pending_count, 0);
    apply_stimulus(1'b0, 1'b1, 16, 1'b1, 16, 1'b0);
    check_output("wake_cancel_count", pending_count, 0);
    idle(2, 1'b0);
    check_output("wake_cancel_ready", next_task_ready, 0);

    // Ack plus wake of the offered task re-offers it; reset mid-offer clears.
    apply_stimulus(1'b0, 1'b1, 15, 1'b0, 0, 1'b0);
    idle(1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 15, 1'b0, 0, 1'b1);
    check_output("rearm_ready_low", next_task_ready, 0);
    check_output("rearm_count", pending_count, 1);
    idle(1, 1'b0);
    check_output("rearm_ready", next_task_ready, 1);
    check_output("rearm_ch", next_task_channel, 3);
    check_output("rearm_th", next_task_thread, 3);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check_output("mid_rst_ready", next_task_ready, 0);
    check_output("mid_rst_any", pending_any, 0);

    // ch6/th0 and ch0/th2 both pending while rr_ptr sits past index 2.
    apply_stimulus(1'b0, 1'b1, 10, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 24, 1'b0, 0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2, 1'b0, 0, 1'b0);
    dut_grants.delete();
    idle(5, 1'b1);
    check_output("prio_grants", dut_grants.size(), 3);
    check_output("prio_g0", dut_grants[0], 10);
`ifdef IO_TASK_SCHED_CH0_PRIORITY_EN
    check_output("prio_g1", dut_grants[1], 2);
    check_output("prio_g2", dut_grants[2], 24);
`else
    check_output("prio_g1", dut_grants[1], 24);
    check_output("prio_g2", dut_grants[2], 2);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      pick = ($urandom_range(3) == 0) ? m_off : int'($urandom_range(N - 1));
      apply_stimulus($urandom_range(63) == 0, $urandom_range(99) < 40,
                     int'($urandom_range(N - 1)), $urandom_range(99) < 20,
                     pick, 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
